// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the VGA adapter pixel-write port between three
// rectangle-drawing clients. Grants one client, scans its rectangle out one
// pixel per clock with off-screen clipping, then pulses done.
// Optional feature macro: PLOT_ARB_RR_EN selects round-robin arbitration;
// when undefined, arbitration is fixed priority (req[0] highest).
module vga_plot_arbiter #(
   parameter int unsigned X_MAX = 160,
   parameter int unsigned Y_MAX = 120
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic [23:0] rx,
   input  logic [20:0] ry,
   input  logic [11:0] rw,
   input  logic [11:0] rh,
   input  logic [26:0] rcol,
   output logic [2:0]  grant,
   output logic [2:0]  done,
   output logic        busy,
   output logic [7:0]  oX,
   output logic [6:0]  oY,
   output logic [8:0]  oColour,
   output logic        oPlot
);

   localparam logic [8:0] X_LIM = 9'(X_MAX);
   localparam logic [7:0] Y_LIM = 8'(Y_MAX);

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  grant_q, grant_d;
   logic [2:0]  done_q, done_d;
   logic        busy_q, busy_d;
   logic [7:0]  ox_q, ox_d;
   logic [6:0]  oy_q, oy_d;
   logic [8:0]  ocol_q, ocol_d;
   logic        oplot_q, oplot_d;
   logic [7:0]  x0_q, x0_d;
   logic [6:0]  y0_q, y0_d;
   logic [3:0]  w_q, w_d;
   logic [3:0]  h_q, h_d;
   logic [8:0]  col_q, col_d;
   logic [3:0]  cx_q, cx_d;
   logic [3:0]  cy_q, cy_d;
   logic [1:0]  win_q, win_d;

   logic [1:0]  sel_c;
   logic [7:0]  lx_c;
   logic [6:0]  ly_c;
   logic [3:0]  lw_c, lh_c;
   logic [8:0]  lcol_c;

`ifdef PLOT_ARB_RR_EN
   logic [1:0] ptr_q, ptr_d;
   logic [2:0] rot_c;
   logic [1:0] pos_c;
   logic [2:0] wsum_c;

   // Round-robin winner: rotate requests so the pointer client is bit 0.
   always_comb begin
      case (ptr_q)
         2'd1:    rot_c = {req[0], req[2], req[1]};
         2'd2:    rot_c = {req[1], req[0], req[2]};
         default: rot_c = req;
      endcase
      casez (rot_c)
         3'b??1:  pos_c = 2'd0;
         3'b?10:  pos_c = 2'd1;
         default: pos_c = 2'd2;
      endcase
      wsum_c = {1'b0, ptr_q} + {1'b0, pos_c};
      sel_c  = (wsum_c >= 3'd3) ? 2'(wsum_c - 3'd3) : wsum_c[1:0];
   end

   // Pointer advances past the winner on each grant.
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == IDLE && req != 3'b000)
         ptr_d = (sel_c == 2'd2) ? 2'd0 : 2'(sel_c + 2'd1);
   end

   // Pointer register.
   always_ff @(posedge clock) begin
      if (reset) ptr_q <= 2'd0;
      else       ptr_q <= ptr_d;
   end
`else
   // Fixed priority winner: lowest index wins.
   always_comb begin
      casez (req)
         3'b??1:  sel_c = 2'd0;
         3'b?10:  sel_c = 2'd1;
         default: sel_c = 2'd2;
      endcase
   end
`endif

   // Pick the selected client's rectangle from the request buses.
   always_comb begin
      case (sel_c)
         2'd1: begin
            lx_c = rx[15:8];  ly_c = ry[13:7];  lw_c = rw[7:4];
            lh_c = rh[7:4];   lcol_c = rcol[17:9];
         end
         2'd2: begin
            lx_c = rx[23:16]; ly_c = ry[20:14]; lw_c = rw[11:8];
            lh_c = rh[11:8];  lcol_c = rcol[26:18];
         end
         default: begin
            lx_c = rx[7:0];   ly_c = ry[6:0];   lw_c = rw[3:0];
            lh_c = rh[3:0];   lcol_c = rcol[8:0];
         end
      endcase
   end

   logic [7:0] px_base;
   logic [6:0] py_base;
   logic [3:0] pcx, pcy;
   logic [8:0] pcol;
   logic       emit;
   logic [8:0] xs;
   logic [7:0] ys;

   // Next-state and registered-output logic; the pixel for the next cycle is
   // computed here so it appears the cycle after grant.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = 3'b000;
      busy_d  = busy_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      ocol_d  = ocol_q;
      oplot_d = 1'b0;
      x0_d    = x0_q;
      y0_d    = y0_q;
      w_d     = w_q;
      h_d     = h_q;
      col_d   = col_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      win_d   = win_q;
      px_base = x0_q;
      py_base = y0_q;
      pcx     = cx_q;
      pcy     = cy_q;
      pcol    = col_q;
      emit    = 1'b0;
      xs      = 9'd0;
      ys      = 8'd0;

      case (state_q)
         IDLE: begin
            grant_d = 3'b000;
            busy_d  = 1'b0;
            if (req != 3'b000) begin
               state_d = DRAW;
               win_d   = sel_c;
               grant_d = 3'b001 << sel_c;
               busy_d  = 1'b1;
               x0_d    = lx_c;
               y0_d    = ly_c;
               w_d     = lw_c;
               h_d     = lh_c;
               col_d   = lcol_c;
               cx_d    = 4'd0;
               cy_d    = 4'd0;
               px_base = lx_c;
               py_base = ly_c;
               pcx     = 4'd0;
               pcy     = 4'd0;
               pcol    = lcol_c;
               emit    = 1'b1;
            end
         end
         DRAW: begin
            if (cx_q == w_q && cy_q == h_q) begin
               state_d = DONE;
               grant_d = 3'b000;
               done_d  = 3'b001 << win_q;
            end else begin
               if (cx_q == w_q) begin
                  cx_d = 4'd0;
                  cy_d = cy_q + 4'd1;
               end else begin
                  cx_d = cx_q + 4'd1;
               end
               pcx  = cx_d;
               pcy  = cy_d;
               emit = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            grant_d = 3'b000;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      xs = {1'b0, px_base} + {5'd0, pcx};
      ys = {1'b0, py_base} + {4'd0, pcy};
      if (emit) begin
         ox_d    = xs[7:0];
         oy_d    = ys[6:0];
         ocol_d  = pcol;
         oplot_d = (xs < X_LIM) && (ys < Y_LIM);
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= 3'b000;
         done_q  <= 3'b000;
         busy_q  <= 1'b0;
         ox_q    <= 8'd0;
         oy_q    <= 7'd0;
         ocol_q  <= 9'd0;
         oplot_q <= 1'b0;
         x0_q    <= 8'd0;
         y0_q    <= 7'd0;
         w_q     <= 4'd0;
         h_q     <= 4'd0;
         col_q   <= 9'd0;
         cx_q    <= 4'd0;
         cy_q    <= 4'd0;
         win_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         ocol_q  <= ocol_d;
         oplot_q <= oplot_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         w_q     <= w_d;
         h_q     <= h_d;
         col_q   <= col_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         win_q   <= win_d;
      end
   end

   assign grant   = grant_q;
   assign done    = done_q;
   assign busy    = busy_q;
   assign oX      = ox_q;
   assign oY      = oy_q;
   assign oColour = ocol_q;
   assign oPlot   = oplot_q;

endmodule
